// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch sequencer.
// Owns the PC, runs a req/ack handshake to instruction memory and holds one
// fetched instruction for decode until it is consumed (stall low).
// Optional feature macro: ALIGN_CHECK_EN -- redirects misaligned branch
// targets to TRAP_VEC and pulses misalign_err; without it the low two bits
// of the loaded PC are simply cleared.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        branch_taken,
   output logic        pc_src,
   output logic [31:0] pc_plus4,
   input  logic [31:0] next_pc,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] pc_out,
   output logic        misalign_err
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t      state;
   state_t      next_state;
   logic [31:0] pc;
   logic        fetch_done;
   logic        consume;

   // Handshake events: ack only counts in FETCH, consumption only in HOLD.
   assign fetch_done = (state == FETCH) && imem_ack;
   assign consume    = (state == HOLD) && !stall;

   // Request and valid are decoded from the state so reset clears them at once.
   assign imem_req    = (state == FETCH);
   assign instr_valid = (state == HOLD);
   assign imem_addr   = pc;
   assign pc_out      = pc;
   assign pc_plus4    = pc + 32'd4;
   assign pc_src      = instr_valid & branch_taken;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= BOOT;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: BOOT -> FETCH -> (ack) HOLD -> (!stall) FETCH.
   always_comb begin
      next_state = state;
      case (state)
         BOOT:    next_state = FETCH;
         FETCH:   if (fetch_done) next_state = HOLD;
         HOLD:    if (consume) next_state = FETCH;
         default: next_state = BOOT;
      endcase
   end

   // Capture the fetched word; it stays put while the instruction is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr <= 32'h0000_0000;
      end else if (fetch_done) begin
         instr <= imem_rdata;
      end
   end

`ifdef ALIGN_CHECK_EN
   // PC update on consume; misaligned targets are trapped with a one-cycle flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc           <= RESET_PC;
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= 1'b0;
         if (consume) begin
            if (next_pc[1:0] != 2'b00) begin
               pc           <= TRAP_VEC;
               misalign_err <= 1'b1;
            end else begin
               pc <= next_pc;
            end
         end
      end
   end
`else
   logic unused_trap;

   // Without the trap vector only the low bits of next_pc are ignored.
   assign unused_trap  = ^{TRAP_VEC, next_pc[1:0]};
   assign misalign_err = 1'b0;

   // PC update on consume with the target forced to word alignment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (consume) begin
         pc <= {next_pc[31:2], 2'b00};
      end
   end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: per-cycle vector table plus a hand-written
// reset-during-fetch sequence. Honours ALIGN_CHECK_EN when defined.
module tb_pc_fetch_unit;

   localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
`ifdef ALIGN_CHECK_EN
   localparam logic [31:0] MIS_ADDR  = TRAP_VEC;
   localparam logic        MIS_PULSE = 1'b1;
`else
   localparam logic [31:0] MIS_ADDR  = 32'h0000_0040;
   localparam logic        MIS_PULSE = 1'b0;
`endif
   localparam int NUM_VECS = 27;

   logic        clk;
   logic        rst_n;
   logic        branch_taken;
   logic        pc_src;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic [31:0] branch_target;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc_out;
   logic        misalign_err;

   int total_checks;
   int passed_checks;

   typedef struct {
      logic        stall;
      logic        bt;
      logic [31:0] target;
      logic        ack;
      logic [31:0] rdata;
      logic        e_req;
      logic        e_valid;
      logic [31:0] e_addr;
      logic [31:0] e_instr;
      logic        e_src;
      logic        e_mis;
   } vec_t;

   vec_t vecs [0:NUM_VECS-1];

   pc_fetch_unit #(
      .RESET_PC(32'h0000_0000),
      .TRAP_VEC(TRAP_VEC)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .branch_taken(branch_taken),
      .pc_src(pc_src),
      .pc_plus4(pc_plus4),
      .next_pc(next_pc),
      .stall(stall),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_ack(imem_ack),
      .imem_rdata(imem_rdata),
      .instr_valid(instr_valid),
      .instr(instr),
      .pc_out(pc_out),
      .misalign_err(misalign_err)
   );

   // External next-PC 2:1 selector that the core places around this block.
   assign next_pc = pc_src ? branch_target : pc_plus4;

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      total_checks++;
      if (act === exp) begin
         passed_checks++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input vec_t v);
      stall         = v.stall;
      branch_taken  = v.bt;
      branch_target = v.target;
      imem_ack      = v.ack;
      imem_rdata    = v.rdata;
   endtask

   initial begin
      total_checks  = 0;
      passed_checks = 0;
      rst_n         = 1'b0;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      imem_ack      = 1'b0;
      imem_rdata    = 32'h0;

      //         stall bt  target        ack  rdata          req  vld  addr          instr          src  mis
      vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0000, 1'b1, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0000, 32'hA000_0000, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0001, 1'b1, 1'b0, 32'h0000_0004, 32'h0,        1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0004, 32'hA000_0001, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0002, 1'b1, 1'b0, 32'h0000_0008, 32'h0,        1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0008, 32'hA000_0002, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h1111_1111, 1'b1, 1'b0, 32'h0000_000C, 32'h0,        1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h2222_2222, 1'b1, 1'b0, 32'h0000_000C, 32'h0,        1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h3333_3333, 1'b1, 1'b0, 32'h0000_000C, 32'h0,        1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0003, 1'b1, 1'b0, 32'h0000_000C, 32'h0,        1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_000C, 32'hA000_0003, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hB000_0000, 1'b1, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 1'b0};
      vecs[13] = '{1'b1, 1'b1, 32'h40,       1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0010, 32'hB000_0000, 1'b1, 1'b0};
      vecs[14] = '{1'b1, 1'b1, 32'h40,       1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0010, 32'hB000_0000, 1'b1, 1'b0};
      vecs[15] = '{1'b1, 1'b1, 32'h40,       1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0010, 32'hB000_0000, 1'b1, 1'b0};
      vecs[16] = '{1'b1, 1'b1, 32'h40,       1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0010, 32'hB000_0000, 1'b1, 1'b0};
      vecs[17] = '{1'b1, 1'b1, 32'h40,       1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0010, 32'hB000_0000, 1'b1, 1'b0};
      vecs[18] = '{1'b0, 1'b1, 32'h40,       1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0010, 32'hB000_0000, 1'b1, 1'b0};
      vecs[19] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hB000_0001, 1'b1, 1'b0, 32'h0000_0040, 32'h0,        1'b0, 1'b0};
      vecs[20] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_0040, 32'hB000_0001, 1'b1, 1'b0};
      vecs[21] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hB000_0002, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,        1'b0, 1'b0};
      vecs[22] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFF_FFFC, 32'hB000_0002, 1'b0, 1'b0};
      vecs[23] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hB000_0003, 1'b1, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 1'b0};
      vecs[24] = '{1'b0, 1'b1, 32'h42,       1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0000, 32'hB000_0003, 1'b1, 1'b0};
      vecs[25] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, MIS_ADDR,      32'h0,        1'b0, MIS_PULSE};
      vecs[26] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, MIS_ADDR,      32'h0,        1'b0, 1'b0};

      // Reset state, held over a couple of clock edges.
      repeat (2) @(negedge clk);
      #1;
      check_output("reset imem_req", {31'd0, imem_req}, 32'd0);
      check_output("reset instr_valid", {31'd0, instr_valid}, 32'd0);
      check_output("reset instr", instr, 32'd0);
      check_output("reset pc_out", pc_out, 32'd0);
      check_output("reset misalign_err", {31'd0, misalign_err}, 32'd0);
      check_output("reset pc_src", {31'd0, pc_src}, 32'd0);

      // Cycle-by-cycle vectors: drive on the falling edge, check 1 ns later.
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NUM_VECS; i++) begin
         apply_stimulus(vecs[i]);
         #1;
         check_output($sformatf("v%0d imem_req", i), {31'd0, imem_req}, {31'd0, vecs[i].e_req});
         check_output($sformatf("v%0d instr_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].e_valid});
         check_output($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].e_addr);
         check_output($sformatf("v%0d pc_out", i), pc_out, vecs[i].e_addr);
         check_output($sformatf("v%0d pc_plus4", i), pc_plus4, vecs[i].e_addr + 32'd4);
         check_output($sformatf("v%0d pc_src", i), {31'd0, pc_src}, {31'd0, vecs[i].e_src});
         check_output($sformatf("v%0d misalign_err", i), {31'd0, misalign_err}, {31'd0, vecs[i].e_mis});
         if (vecs[i].e_valid) begin
            check_output($sformatf("v%0d instr", i), instr, vecs[i].e_instr);
         end
         @(negedge clk);
      end

      // Reset asserted mid-fetch with an ack pending: outputs drop at once.
      imem_ack   = 1'b1;
      imem_rdata = 32'hC000_0000;
      rst_n      = 1'b0;
      #1;
      check_output("rst mid-fetch imem_req", {31'd0, imem_req}, 32'd0);
      check_output("rst mid-fetch instr_valid", {31'd0, instr_valid}, 32'd0);
      check_output("rst mid-fetch pc_out", pc_out, 32'd0);
      check_output("rst mid-fetch instr", instr, 32'd0);
      @(negedge clk);
      check_output("rst held instr_valid", {31'd0, instr_valid}, 32'd0);
      rst_n    = 1'b1;
      imem_ack = 1'b0;
      #1;
      check_output("post-rst boot imem_req", {31'd0, imem_req}, 32'd0);
      @(negedge clk);
      imem_ack   = 1'b1;
      imem_rdata = 32'hC000_0001;
      #1;
      check_output("post-rst fetch imem_req", {31'd0, imem_req}, 32'd1);
      check_output("post-rst fetch imem_addr", imem_addr, 32'd0);
      @(negedge clk);
      imem_ack = 1'b0;
      #1;
      check_output("post-rst hold instr_valid", {31'd0, instr_valid}, 32'd1);
      check_output("post-rst hold instr", instr, 32'hC000_0001);

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
